// File: rtl/hazard_pkg.sv
// Shared types and helpers for the RAW hazard scoreboard.
// Tags store dest at MAX_REG_W bits; narrower register files zero-extend into it.
package hazard_pkg;

   localparam int MAX_REG_W = 8;
   localparam int FWD_RF    = 0;

   typedef struct packed {
      logic                 valid;
      logic                 wb_en;
      logic                 mem_read;
      logic [MAX_REG_W-1:0] dest;
   } hazard_tag_t;

   function automatic int fwd_sel_w(input int stages);
      return (stages < 1) ? 1 : $clog2(stages + 1);
   endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Compares one ID source operand against every in-flight tag.
// Reports all matching stages, the youngest one, and whether stage 0 is a load.
module hazard_src_match
   import hazard_pkg::*;
#(
   parameter int STAGES = 2,
   parameter int REG_W  = 5,
   parameter int SEL_W  = fwd_sel_w(STAGES)
) (
   input  logic                    id_valid,
   input  logic [REG_W-1:0]        src,
   input  logic                    has_src,
   input  hazard_tag_t [STAGES-1:0] tags,
   output logic [STAGES-1:0]       match,
   output logic [SEL_W-1:0]        youngest,
   output logic                    load_use
);

   for (genvar k = 0; k < STAGES; k++) begin : g_cmp
      assign match[k] = id_valid & has_src & tags[k].valid & tags[k].wb_en &
                        (tags[k].dest == MAX_REG_W'(src));
   end

   // Scan oldest to youngest so the lowest matching stage is left in place.
   always_comb begin
      youngest = '0;
      for (int k = STAGES - 1; k >= 0; k--)
         if (match[k]) youngest = SEL_W'(k);
   end

   assign load_use = match[0] & tags[0].mem_read;

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard beside ID: tag pipeline, stall/forward decisions, stall counter.
// Build option FORWARDING_EN: forward from any tracked stage, stall only on load-use.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_W  = 5,
   parameter int STAGES = 2,
   parameter int CNT_W  = 32,
   localparam int SEL_W = fwd_sel_w(STAGES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] src1,
   input  logic [REG_W-1:0] src2,
   input  logic             has_src1,
   input  logic             has_src2,
   input  logic [REG_W-1:0] id_dest,
   input  logic             id_wb_en,
   input  logic             id_mem_read,
   input  logic             mem_ready,
   input  logic             perf_clr,
   output logic             hazard_detected,
   output logic             pipe_stall,
   output logic [SEL_W-1:0] fwd_sel1,
   output logic [SEL_W-1:0] fwd_sel2,
   output logic [CNT_W-1:0] stall_cycles
);

   hazard_tag_t [STAGES-1:0] tags;
   hazard_tag_t              id_tag;
   logic [STAGES-1:0]        match1, match2;
   logic [SEL_W-1:0]         young1, young2;
   logic                     lu1, lu2;
   logic                     haz;
   logic [SEL_W-1:0]         sel1, sel2;
   logic [CNT_W-1:0]         cnt;

   hazard_src_match #(.STAGES(STAGES), .REG_W(REG_W), .SEL_W(SEL_W)) u_match1 (
      .id_valid(id_valid), .src(src1), .has_src(has_src1), .tags(tags),
      .match(match1), .youngest(young1), .load_use(lu1)
   );

   hazard_src_match #(.STAGES(STAGES), .REG_W(REG_W), .SEL_W(SEL_W)) u_match2 (
      .id_valid(id_valid), .src(src2), .has_src(has_src2), .tags(tags),
      .match(match2), .youngest(young2), .load_use(lu2)
   );

   always_comb begin
      haz  = 1'b0;
      sel1 = SEL_W'(FWD_RF);
      sel2 = SEL_W'(FWD_RF);
`ifdef FORWARDING_EN
      haz = lu1 | lu2;
      // A source stalled by load-use reads nothing useful this cycle, so keep it on the RF.
      if (|match1 && !lu1) sel1 = young1 + SEL_W'(1);
      if (|match2 && !lu2) sel2 = young2 + SEL_W'(1);
`else
      haz = |match1 | |match2;
`endif
   end

   always_comb begin
      id_tag = '0;
      if (id_valid && !haz) begin
         id_tag.valid    = 1'b1;
         id_tag.wb_en    = id_wb_en;
         id_tag.mem_read = id_mem_read;
         id_tag.dest     = MAX_REG_W'(id_dest);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tags <= '0;
         cnt  <= '0;
      end else begin
         if (perf_clr)                            cnt <= '0;
         else if (haz && mem_ready && !(&cnt))    cnt <= cnt + CNT_W'(1);
         if (mem_ready) begin
            tags[0] <= id_tag;
            for (int k = 1; k < STAGES; k++) tags[k] <= tags[k-1];
         end
      end
   end

   assign hazard_detected = ~rst & haz;
   assign pipe_stall      = rst | haz | ~mem_ready;
   assign fwd_sel1        = rst ? '0 : sel1;
   assign fwd_sel2        = rst ? '0 : sel2;
   assign stall_cycles    = rst ? '0 : cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard; expected outputs come from a cycle model
// queued at drive time and popped at sampling, plus directed constant checks.
module tb_hazard_scoreboard;

   localparam int REG_W  = 5;
   localparam int STAGES = 2;
   localparam int CNT_W  = 4;
   localparam int SEL_W  = 2;
   localparam int CMAX   = 15;
`ifdef FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst = 1'b1, id_valid = 1'b0, has_src1 = 1'b0, has_src2 = 1'b0;
   logic [REG_W-1:0] src1 = '0, src2 = '0, id_dest = '0;
   logic             id_wb_en = 1'b0, id_mem_read = 1'b0, mem_ready = 1'b1, perf_clr = 1'b0;
   logic             hazard_detected, pipe_stall;
   logic [SEL_W-1:0] fwd_sel1, fwd_sel2;
   logic [CNT_W-1:0] stall_cycles;

   hazard_scoreboard #(.REG_W(REG_W), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
      .has_src1(has_src1), .has_src2(has_src2), .id_dest(id_dest), .id_wb_en(id_wb_en),
      .id_mem_read(id_mem_read), .mem_ready(mem_ready), .perf_clr(perf_clr),
      .hazard_detected(hazard_detected), .pipe_stall(pipe_stall),
      .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall_cycles(stall_cycles)
   );

   typedef struct { logic haz; logic stall; int f1; int f2; int cnt; } exp_t;
   exp_t exp_q[$];

   int n_chk = 0, n_err = 0;
   int mv[STAGES], mwb[STAGES], mld[STAGES], mdst[STAGES];
   int mcnt = 0;
   logic e_haz = 1'b0;
   int last_steps = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int youngest_of(input int s, input logic h);
      for (int k = 0; k < STAGES; k++)
         if (id_valid && h && mv[k] != 0 && mwb[k] != 0 && mdst[k] == s) return k;
      return -1;
   endfunction

   task automatic model_eval(output exp_t e);
      int m1, m2;
      bit lu1, lu2;
      e = '{haz: 1'b0, stall: 1'b1, f1: 0, f2: 0, cnt: 0};
      if (!rst) begin
         m1 = youngest_of(int'(src1), has_src1);
         m2 = youngest_of(int'(src2), has_src2);
         if (FWD) begin
            lu1 = (m1 == 0) && mld[0] != 0;
            lu2 = (m2 == 0) && mld[0] != 0;
            e.haz = lu1 || lu2;
            e.f1  = (m1 >= 0 && !lu1) ? m1 + 1 : 0;
            e.f2  = (m2 >= 0 && !lu2) ? m2 + 1 : 0;
         end else begin
            e.haz = (m1 >= 0) || (m2 >= 0);
         end
         e.stall = e.haz || !mem_ready;
         e.cnt   = mcnt;
      end
   endtask

   task automatic model_clock();
      if (rst) begin
         for (int k = 0; k < STAGES; k++) mv[k] = 0;
         mcnt = 0;
      end else begin
         if (perf_clr) mcnt = 0;
         else if (e_haz && mem_ready && mcnt < CMAX) mcnt++;
         if (mem_ready) begin
            for (int k = STAGES - 1; k > 0; k--) begin
               mv[k] = mv[k-1]; mwb[k] = mwb[k-1]; mld[k] = mld[k-1]; mdst[k] = mdst[k-1];
            end
            mv[0]   = (id_valid && !e_haz) ? 1 : 0;
            mwb[0]  = int'(id_wb_en);
            mld[0]  = int'(id_mem_read);
            mdst[0] = int'(id_dest);
         end
      end
   endtask

   task automatic step();
      exp_t e, got;
      model_eval(e);
      exp_q.push_back(e);
      e_haz = e.haz;
      @(negedge clk);
      got = exp_q.pop_front();
      check("hazard_detected", hazard_detected, got.haz);
      check("pipe_stall", pipe_stall, got.stall);
      check("fwd_sel1", fwd_sel1, got.f1);
      check("fwd_sel2", fwd_sel2, got.f2);
      check("stall_cycles", stall_cycles, got.cnt);
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic set_id(input logic v, input int s1, input logic h1, input int s2,
                         input logic h2, input int d, input logic wb, input logic ld);
      id_valid = v; src1 = REG_W'(s1); has_src1 = h1; src2 = REG_W'(s2); has_src2 = h2;
      id_dest = REG_W'(d); id_wb_en = wb; id_mem_read = ld;
   endtask

   task automatic bubble(input int n);
      set_id(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
      for (int i = 0; i < n; i++) step();
   endtask

   // Holds the current ID instruction until the model says it has been accepted.
   task automatic issue(input int s1, input logic h1, input int s2, input logic h2,
                        input int d, input logic wb, input logic ld);
      logic done;
      done = 1'b0;
      last_steps = 0;
      set_id(1'b1, s1, h1, s2, h2, d, wb, ld);
      for (int i = 0; i < 20 && !done; i++) begin
         step();
         last_steps++;
         if (!e_haz && mem_ready) done = 1'b1;
      end
      check("issue_accepted", done, 1'b1);
   endtask

   initial begin
      // reset state, then idle
      rst = 1'b1;
      bubble(2);
      rst = 1'b0;
      bubble(3);
      check("t1_haz", hazard_detected, 1'b0);
      check("t1_stall", pipe_stall, 1'b0);
      check("t1_cnt", stall_cycles, 0);

      // ALU producer r3 then consumer src1=r3
      issue(0, 1'b0, 0, 1'b0, 3, 1'b1, 1'b0);
      set_id(1'b1, 3, 1'b1, 0, 1'b0, 9, 1'b1, 1'b0);
      #1;
      check("t2_fwd1", fwd_sel1, FWD ? 1 : 0);
      check("t2_haz", hazard_detected, FWD ? 1'b0 : 1'b1);
      issue(3, 1'b1, 0, 1'b0, 9, 1'b1, 1'b0);
      check("t2_cycles", last_steps, FWD ? 1 : 3);
      bubble(2);
      check("t2_cnt", stall_cycles, FWD ? 0 : 2);

      // load r4 then consumer src2=r4
      perf_clr = 1'b1; bubble(1); perf_clr = 1'b0;
      issue(0, 1'b0, 0, 1'b0, 4, 1'b1, 1'b1);
      set_id(1'b1, 0, 1'b0, 4, 1'b1, 10, 1'b1, 1'b0);
      #1;
      check("t3_haz", hazard_detected, 1'b1);
      issue(0, 1'b0, 4, 1'b1, 10, 1'b1, 1'b0);
      check("t3_cycles", last_steps, FWD ? 2 : 3);
      bubble(2);
      check("t3_cnt", stall_cycles, FWD ? 1 : 2);

      // same hazard while memory is not ready
      perf_clr = 1'b1; bubble(1); perf_clr = 1'b0;
      issue(0, 1'b0, 0, 1'b0, 5, 1'b1, 1'b1);
      set_id(1'b1, 5, 1'b1, 0, 1'b0, 11, 1'b1, 1'b0);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) step();
      check("t4_stall", pipe_stall, 1'b1);
      check("t4_cnt", stall_cycles, 0);
      mem_ready = 1'b1;
      issue(5, 1'b1, 0, 1'b0, 11, 1'b1, 1'b0);
      check("t4_cycles", last_steps, FWD ? 2 : 3);
      bubble(2);
      check("t4_cnt_after", stall_cycles, FWD ? 1 : 2);

      // unread source and non-writing producer never match
      issue(0, 1'b0, 0, 1'b0, 6, 1'b1, 1'b0);
      set_id(1'b1, 6, 1'b0, 0, 1'b1, 12, 1'b1, 1'b0);
      #1;
      check("t5_fwd1", fwd_sel1, 0);
      issue(6, 1'b0, 0, 1'b1, 12, 1'b1, 1'b0);
      check("t5_no_src_cycles", last_steps, 1);
      issue(0, 1'b0, 0, 1'b0, 7, 1'b0, 1'b0);
      issue(7, 1'b1, 0, 1'b0, 13, 1'b0, 1'b0);
      check("t5_no_wb_cycles", last_steps, 1);
      bubble(2);

      // saturation and clear-over-increment
      perf_clr = 1'b1; bubble(1); perf_clr = 1'b0;
      for (int i = 0; i < 20 && mcnt < CMAX - 1; i++) begin
         issue(0, 1'b0, 0, 1'b0, 8, 1'b1, 1'b1);
         issue(8, 1'b1, 0, 1'b0, 14, 1'b0, 1'b0);
      end
      check("t6_pre", stall_cycles, CMAX - 1);
      for (int i = 0; i < 3; i++) begin
         issue(0, 1'b0, 0, 1'b0, 8, 1'b1, 1'b1);
         issue(8, 1'b1, 0, 1'b0, 14, 1'b0, 1'b0);
      end
      check("t6_sat", stall_cycles, CMAX);
      issue(0, 1'b0, 0, 1'b0, 9, 1'b1, 1'b1);
      set_id(1'b1, 9, 1'b1, 0, 1'b0, 15, 1'b0, 1'b0);
      perf_clr = 1'b1;
      step();
      perf_clr = 1'b0;
      check("t6_clr", stall_cycles, 0);
      issue(9, 1'b1, 0, 1'b0, 15, 1'b0, 1'b0);
      bubble(2);

      // reset in the middle of a stall drops in-flight tags
      issue(0, 1'b0, 0, 1'b0, 10, 1'b1, 1'b1);
      set_id(1'b1, 10, 1'b1, 0, 1'b0, 16, 1'b0, 1'b0);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t7_haz", hazard_detected, 1'b0);
      check("t7_cnt", stall_cycles, 0);
      step();
      bubble(2);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
